// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

  // Default operand widths
  localparam int unsigned DEF_N_BITS = 8;
  localparam int unsigned DEF_D_BITS = 4;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_paso.sv
// One restoring division step: trial-subtract the divisor from {rem, next dividend bit}.
module div_paso
  import div_pkg::*;
#(
  parameter int unsigned D_BITS = DEF_D_BITS
) (
  input  logic [D_BITS-1:0] rem_in,
  input  logic              dvd_bit,
  input  logic [D_BITS-1:0] divisor,
  output logic [D_BITS-1:0] rem_out,
  output logic              q_bit
);

  logic [D_BITS:0] trial;
  logic [D_BITS:0] diff;

  // Subtract when the widened partial remainder covers the divisor, otherwise restore
  always_comb begin
    trial   = {rem_in, dvd_bit};
    diff    = trial - {1'b0, divisor};
    q_bit   = (trial >= {1'b0, divisor});
    // When no subtraction happens trial < divisor, so its MSB is zero and truncation is safe
    rem_out = q_bit ? diff[D_BITS-1:0] : trial[D_BITS-1:0];
  end

endmodule

// File: rtl/seq_divisor.sv
// Sequential unsigned restoring divider: one quotient bit per cycle, MSB first.
module seq_divisor
  import div_pkg::*;
#(
  parameter int unsigned N_BITS = DEF_N_BITS,
  parameter int unsigned D_BITS = DEF_D_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_BITS-1:0] dividendo,
  input  logic [D_BITS-1:0] divisor,
  output logic [N_BITS-1:0] cociente,
  output logic [D_BITS-1:0] residuo,
  output logic              busy,
  output logic              done,
  output logic              div_err
);

  localparam int unsigned CW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  div_state_t        state;
  // Dividend shifts out MSB-first while quotient bits shift in at the LSB
  logic [N_BITS-1:0] dvd_q;
  logic [D_BITS-1:0] dsr_q;
  logic [D_BITS-1:0] rem_q;
  logic [CW-1:0]     cnt_q;
  // Zero divisor captured; next cycle jumps straight to DONE without entering RUN
  logic              zero_pend;

  logic [D_BITS-1:0] rem_nx;
  logic              q_bit;
  logic [N_BITS-1:0] dvd_shift;

  div_paso #(
    .D_BITS (D_BITS)
  ) u_paso (
    .rem_in  (rem_q),
    .dvd_bit (dvd_q[N_BITS-1]),
    .divisor (dsr_q),
    .rem_out (rem_nx),
    .q_bit   (q_bit)
  );

  // Shift the next quotient bit into the dividend register
  always_comb begin
    dvd_shift = {dvd_q[N_BITS-2:0], q_bit};
  end

  // Controller FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      zero_pend <= 1'b0;
      cociente  <= '0;
      residuo   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_err   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (zero_pend) begin
            state     <= DONE;
            zero_pend <= 1'b0;
            cociente  <= '1;
            residuo   <= dvd_q[D_BITS-1:0];
            done      <= 1'b1;
            div_err   <= 1'b1;
          end else if (start) begin
            dvd_q   <= dividendo;
            dsr_q   <= divisor;
            rem_q   <= '0;
            cnt_q   <= CW'(N_BITS - 1);
            div_err <= 1'b0;
            if (divisor == '0) begin
              zero_pend <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          dvd_q <= dvd_shift;
          rem_q <= rem_nx;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state    <= DONE;
            busy     <= 1'b0;
            cociente <= dvd_shift;
            residuo  <= rem_nx;
            done     <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divisor.sv
// Scoreboard bench for seq_divisor: expected results queued at acceptance, checked on done.
module tb_seq_divisor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividendo;
  logic [3:0] divisor;
  logic [7:0] cociente;
  logic [3:0] residuo;
  logic       busy;
  logic       done;
  logic       div_err;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       e;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks;
  int         n_errors;
  int         done_run;
  logic [7:0] prev_q;
  logic [3:0] prev_r;

  seq_divisor #(
    .N_BITS (8),
    .D_BITS (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividendo (dividendo),
    .divisor   (divisor),
    .cociente  (cociente),
    .residuo   (residuo),
    .busy      (busy),
    .done      (done),
    .div_err   (div_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [3:0] b);
    exp_t x;
    if (b == 4'd0) begin
      x.q = 8'hFF;
      x.r = a[3:0];
      x.e = 1'b1;
    end else begin
      x.q = a / {4'd0, b};
      x.r = 4'(a % {4'd0, b});
      x.e = 1'b0;
    end
    return x;
  endfunction

  // Monitor: pop and compare on every done, and require a one-cycle pulse
  always @(negedge clk) begin
    exp_t x;
    done_run = done ? done_run + 1 : 0;
    if (!rst && done) begin
      check("done_width", done_run, 1);
      if (sb_q.size() == 0) begin
        check("unexpected_done", sb_q.size(), 1);
      end else begin
        x = sb_q.pop_front();
        check("cociente", cociente, x.q);
        check("residuo", residuo, x.r);
        check("div_err", div_err, x.e);
        check("busy_at_done", busy, 0);
      end
    end
  end

  // Count edges from acceptance (edge 1) until done is seen; bounded
  task automatic wait_done(output int lat);
    lat = 1;
    forever begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) break;
      if (lat > 40) begin
        check("done_timeout", lat, 40);
        break;
      end
    end
  endtask

  task automatic do_op(input logic [7:0] a, input logic [3:0] b);
    int   lat;
    exp_t x;
    x = model(a, b);
    @(negedge clk);
    start     = 1'b1;
    dividendo = a;
    divisor   = b;
    @(posedge clk);
    sb_q.push_back(x);
    #1;
    start     = 1'b0;
    dividendo = ~a;
    divisor   = ~b;
    @(negedge clk);
    check("hold_cociente", cociente, prev_q);
    check("hold_residuo", residuo, prev_r);
    check("busy_run", busy, (b != 4'd0));
    wait_done(lat);
    check("latency", lat, (b == 4'd0) ? 2 : 9);
    prev_q = x.q;
    prev_r = x.r;
  endtask

  initial begin
    int   lat;
    exp_t x;
    n_checks  = 0;
    n_errors  = 0;
    done_run  = 0;
    prev_q    = '0;
    prev_r    = '0;
    rst       = 1'b1;
    start     = 1'b1;
    dividendo = 8'hAA;
    divisor   = 4'h3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cociente", cociente, 0);
    check("rst_residuo", residuo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", div_err, 0);
    rst   = 1'b0;
    start = 1'b0;

    // Directed cases, including divide-by-zero followed by a normal op
    do_op(8'h36, 4'h9);
    do_op(8'd100, 4'd7);
    do_op(8'd255, 4'd1);
    do_op(8'd3, 4'd15);
    do_op(8'h5A, 4'h0);
    do_op(8'h36, 4'h9);

    // Start held high with operands changed mid-run
    @(negedge clk);
    start     = 1'b1;
    dividendo = 8'd100;
    divisor   = 4'd7;
    @(posedge clk);
    sb_q.push_back(model(8'd100, 4'd7));
    #1;
    dividendo = 8'd200;
    divisor   = 4'd3;
    wait_done(lat);
    check("held_latency", lat, 9);
    @(negedge clk);
    check("held_idle_busy", busy, 0);
    @(posedge clk);
    sb_q.push_back(model(8'd200, 4'd3));
    #1;
    start = 1'b0;
    @(negedge clk);
    check("held_busy2", busy, 1);
    wait_done(lat);
    check("held_latency2", lat, 9);

    // Reset during step 4 of RUN discards the operation
    @(negedge clk);
    start     = 1'b1;
    dividendo = 8'd54;
    divisor   = 4'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_cociente", cociente, 0);
    check("mid_rst_residuo", residuo, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", div_err, 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("no_done_after_rst", sb_q.size(), 0);
    prev_q = '0;
    prev_r = '0;
    do_op(8'd54, 4'd9);

    // Exhaustive sweep
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op(8'(a), 4'(b));
      end
    end

    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
